// File: rtl/cpu_pkg.sv
// Shared CPU definitions: datapath width, fetch FSM encoding and the reset-time
// instruction word.
package cpu_pkg;

    localparam int XLEN = 32;

    localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        HOLD = 2'd2,
        ERR  = 2'd3
    } fetch_state_t;

endpackage

// File: rtl/pc_next.sv
// Next-PC selection: sequential PC+4 or branch target PC+ImmOp, both modulo 2^32,
// plus a flag for a target that is not word aligned.
module pc_next
    import cpu_pkg::*;
(
    input  logic [XLEN-1:0] PC,
    input  logic [XLEN-1:0] ImmOp,
    input  logic            PCsrc,
    output logic [XLEN-1:0] next_pc,
    output logic            misaligned
);

    logic [XLEN-1:0] w_offset;

    assign w_offset   = PCsrc ? ImmOp : XLEN'(4);
    assign next_pc    = PC + w_offset;
    assign misaligned = |next_pc[1:0];

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: one outstanding req/ack memory fetch, a registered
// instruction handed to decode over valid/ready, and PC update on acceptance.
module fetch_unit
    import cpu_pkg::*;
#(
    parameter logic [XLEN-1:0] RESET_PC = 32'h0000_0000
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            PCsrc,
    input  logic [XLEN-1:0] ImmOp,
    output logic            imem_req,
    output logic [XLEN-1:0] imem_addr,
    input  logic            imem_ack,
    input  logic [XLEN-1:0] imem_rdata,
    output logic [XLEN-1:0] instr,
    output logic            instr_valid,
    input  logic            instr_ready,
    output logic [XLEN-1:0] PC,
    output logic            fetch_err
);

    fetch_state_t    r_state;
    fetch_state_t    w_state_next;
    logic [XLEN-1:0] r_pc;
    logic [XLEN-1:0] r_instr;
    logic [XLEN-1:0] w_next_pc;
    logic            w_misaligned;
    logic            w_accept;
    logic            w_capture;

    pc_next u_pc_next (
        .PC         (r_pc),
        .ImmOp      (ImmOp),
        .PCsrc      (PCsrc),
        .next_pc    (w_next_pc),
        .misaligned (w_misaligned)
    );

    assign w_capture = (r_state == REQ) && imem_ack;
    assign w_accept  = (r_state == HOLD) && instr_ready;

    // NOTE: state registers use non-blocking assignments so every flop samples
    // pre-edge values regardless of process ordering.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        // NOTE: default first so every path assigns w_state_next and no latch is inferred.
        w_state_next = r_state;
        case (r_state)
            IDLE: w_state_next = REQ;
            REQ:  if (imem_ack) w_state_next = HOLD;
            HOLD: if (instr_ready) w_state_next = w_misaligned ? ERR : REQ;
            ERR:  w_state_next = ERR;
            default: w_state_next = IDLE;
        endcase
    end

    // A misaligned target leaves the PC pointing at the offending instruction.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_pc    <= RESET_PC;
            r_instr <= NOP_INSTR;
        end else begin
            if (w_capture) begin
                r_instr <= imem_rdata;
            end
            if (w_accept && !w_misaligned) begin
                r_pc <= w_next_pc;
            end
        end
    end

    // Handshake outputs decode from state only, so reset drops them asynchronously.
    assign imem_req    = (r_state == REQ);
    assign instr_valid = (r_state == HOLD);
    assign fetch_err   = (r_state == ERR);
    assign imem_addr   = r_pc;
    assign PC          = r_pc;
    assign instr       = r_instr;

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: transaction-level reference model of the
// PC sequence with directed corner cases and randomized latency/stall/branches.
module tb_fetch_unit;

    localparam logic [31:0] TB_RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP         = 32'h0000_0013;

    logic        clk;
    logic        rst;
    logic        PCsrc;
    logic [31:0] ImmOp;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_rdata;
    logic [31:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic [31:0] PC;
    logic        fetch_err;

    int          n_checks;
    int          n_fail;
    logic [31:0] model_pc;

    fetch_unit #(.RESET_PC(TB_RESET_PC)) dut (
        .clk         (clk),
        .rst         (rst),
        .PCsrc       (PCsrc),
        .ImmOp       (ImmOp),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_ack    (imem_ack),
        .imem_rdata  (imem_rdata),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .PC          (PC),
        .fetch_err   (fetch_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic logic [31:0] rom(input logic [31:0] a);
        return (a * 32'h9E37_79B1) ^ 32'h5A3C_96E0;
    endfunction

    task automatic check_reset_outputs(input string tag);
        check({tag, "_req"},   imem_req,    1'b0);
        check({tag, "_valid"}, instr_valid, 1'b0);
        check({tag, "_instr"}, instr,       NOP);
        check({tag, "_pc"},    PC,          TB_RESET_PC);
        check({tag, "_err"},   fetch_err,   1'b0);
    endtask

    task automatic wait_req();
        int n = 0;
        while (imem_req !== 1'b1 && n < 16) begin
            @(negedge clk);
            n++;
        end
        check("req_wait", imem_req, 1'b1);
    endtask

    // One full transaction, entered and left on a falling edge.
    task automatic fetch(input int delay, input int stall, input logic src, input logic [31:0] imm);
        logic [31:0] word;
        logic [31:0] nxt;
        wait_req();
        check("req_addr", imem_addr, model_pc);
        check("valid_in_req", instr_valid, 1'b0);
        for (int i = 0; i < delay; i++) begin
            imem_ack = 1'b0;
            @(negedge clk);
            check("addr_stable", imem_addr, model_pc);
            check("req_held", imem_req, 1'b1);
        end
        word       = rom(model_pc);
        imem_ack   = 1'b1;
        imem_rdata = word;
        @(negedge clk);
        imem_ack   = 1'b0;
        imem_rdata = $urandom;
        check("valid_after_ack", instr_valid, 1'b1);
        check("instr", instr, word);
        check("pc_hold", PC, model_pc);
        check("req_drop", imem_req, 1'b0);
        for (int i = 0; i < stall; i++) begin
            instr_ready = 1'b0;
            imem_ack    = 1'($urandom_range(0, 1));
            PCsrc       = 1'($urandom_range(0, 1));
            ImmOp       = $urandom;
            @(negedge clk);
            check("stall_valid", instr_valid, 1'b1);
            check("stall_instr", instr, word);
            check("stall_pc", PC, model_pc);
            check("stall_no_req", imem_req, 1'b0);
        end
        imem_ack    = 1'b0;
        instr_ready = 1'b1;
        PCsrc       = src;
        ImmOp       = imm;
        @(negedge clk);
        instr_ready = 1'b0;
        PCsrc       = 1'($urandom_range(0, 1));
        ImmOp       = $urandom;
        nxt = src ? model_pc + imm : model_pc + 32'd4;
        if (nxt[1:0] != 2'b00) begin
            check("err_set", fetch_err, 1'b1);
            check("err_no_req", imem_req, 1'b0);
            check("err_no_valid", instr_valid, 1'b0);
            check("err_pc", PC, model_pc);
        end else begin
            model_pc = nxt;
            check("no_err", fetch_err, 1'b0);
            check("next_req", imem_req, 1'b1);
            check("next_addr", imem_addr, model_pc);
            check("next_valid_low", instr_valid, 1'b0);
        end
    endtask

    task automatic apply_reset();
        @(negedge clk);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst");
        @(negedge clk);
        rst      = 1'b0;
        model_pc = TB_RESET_PC;
        check("idle_no_req", imem_req, 1'b0);
    endtask

    initial begin
        n_checks    = 0;
        n_fail      = 0;
        rst         = 1'b1;
        PCsrc       = 1'b0;
        ImmOp       = 32'h0;
        imem_ack    = 1'b0;
        imem_rdata  = 32'h0;
        instr_ready = 1'b0;
        model_pc    = TB_RESET_PC;
        #1;
        check_reset_outputs("por");
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("idle_no_req", imem_req, 1'b0);

        // Zero-wait sequential stream 0,4,8,0xC then a backward branch from 0x10.
        for (int i = 0; i < 4; i++) fetch(0, 0, 1'b0, 32'h0);
        check("pc_at_0x10", model_pc, 32'h10);
        fetch(0, 0, 1'b1, 32'hFFFF_FFF8);
        check("branch_back", imem_addr, 32'h08);
        fetch(0, 0, 1'b0, 32'h0);
        fetch(0, 0, 1'b0, 32'h0);
        fetch(0, 0, 1'b0, 32'h0);
        check("seq_after_0x10", imem_addr, 32'h14);

        // Slow memory and stalled decode.
        fetch(3, 4, 1'b0, 32'h0);

        // Wrap from the top of the address space.
        fetch(0, 0, 1'b1, 32'hFFFF_FFFC - model_pc);
        check("pc_top", imem_addr, 32'hFFFF_FFFC);
        fetch(1, 1, 1'b0, 32'h0);
        check("wrap_zero", imem_addr, 32'h0000_0000);

        for (int t = 0; t < 40; t++) begin
            fetch($urandom_range(0, 3), $urandom_range(0, 3),
                  1'($urandom_range(0, 1)), $urandom & 32'hFFFF_FFFC);
        end

        // Misaligned branch target is terminal.
        begin
            logic [31:0] pc_at_err;
            pc_at_err = model_pc;
            fetch(0, 1, 1'b1, 32'h6);
            for (int i = 0; i < 6; i++) begin
                imem_ack    = 1'($urandom_range(0, 1));
                instr_ready = 1'($urandom_range(0, 1));
                @(negedge clk);
                check("err_sticky", fetch_err, 1'b1);
                check("err_req_low", imem_req, 1'b0);
                check("err_valid_low", instr_valid, 1'b0);
                check("err_pc_frozen", PC, pc_at_err);
            end
            imem_ack    = 1'b0;
            instr_ready = 1'b0;
        end

        apply_reset();
        fetch(0, 0, 1'b0, 32'h0);
        fetch(2, 0, 1'b0, 32'h0);

        // Reset while a request is outstanding, with acks during reset and IDLE.
        wait_req();
        rst      = 1'b1;
        imem_ack = 1'b1;
        #1;
        check_reset_outputs("rst_in_req");
        @(negedge clk);
        check_reset_outputs("rst_held");
        rst      = 1'b0;
        model_pc = TB_RESET_PC;
        check("late_ack_idle_req", imem_req, 1'b0);
        @(negedge clk);
        check("late_ack_ignored", instr_valid, 1'b0);
        check("restart_req", imem_req, 1'b1);
        check("restart_addr", imem_addr, TB_RESET_PC);
        imem_ack = 1'b0;
        fetch(0, 0, 1'b0, 32'h0);

        // Reset while an instruction waits in HOLD.
        wait_req();
        imem_ack   = 1'b1;
        imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        imem_ack = 1'b0;
        check("hold_before_rst", instr_valid, 1'b1);
        rst = 1'b1;
        #1;
        check_reset_outputs("rst_in_hold");
        @(negedge clk);
        rst      = 1'b0;
        model_pc = TB_RESET_PC;
        fetch(0, 0, 1'b0, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/fetch_unit.md
# fetch_unit

Instruction fetch stage directly upstream of the control unit. Holds the program counter, fetches one 32-bit instruction at a time from instruction memory over a req/ack handshake, and presents it to decode/control with a valid/ready handshake. It consumes the control unit's `PCsrc` and the sign-extended immediate to select the next PC, either PC+4 or the branch target.

## Interface
Parameters:
- `RESET_PC`, default 32'h0000_0000: PC value loaded on reset; must be 4-byte aligned.

Ports:
- `clk`  in  1  single clock; all state updates on the rising edge.
- `rst`  in  1  reset, asynchronous and active-high.
- `PCsrc`  in  1  branch-taken from the control unit; valid in the cycle the current instruction is accepted.
- `ImmOp`  in  32  sign-extended branch offset for the current instruction.
- `imem_req`  out  1  fetch request.
- `imem_addr`  out  32  fetch address; always equals `PC` while `imem_req`=1.
- `imem_ack`  in  1  memory returns `imem_rdata` this cycle.
- `imem_rdata`  in  32  fetched instruction word.
- `instr`  out  32  registered instruction to decode.
- `instr_valid`  out  1  `instr` holds a fetched instruction.
- `instr_ready`  in  1  decode/control consumes `instr` this cycle.
- `PC`  out  32  address of `instr` / current fetch.
- `fetch_err`  out  1  sticky: misaligned branch target detected.

## Operation
- FSM states: IDLE, REQ, HOLD, ERR.
- IDLE: entered only from reset. Moves to REQ on the first clock edge after `rst` deasserts.
- REQ:
  - `imem_req`=1 and `imem_addr`=`PC`, both held stable until `imem_ack`.
  - On `imem_ack`, `instr`<=`imem_rdata` and the FSM moves to HOLD.
  - `imem_ack` in the same cycle `imem_req` first rises is legal.
- HOLD:
  - `instr_valid`=1 and `imem_req`=0.
  - On `instr_ready`, the block computes next = `PCsrc` ? `PC`+`ImmOp` : `PC`+4.
  - If next[1:0]≠0, the FSM goes to ERR. `PC` stays unchanged and `fetch_err`<=1.
  - Otherwise `PC`<=next and the FSM goes to REQ.
  - Without `instr_ready`, `instr` and `PC` hold.
- ERR: terminal until reset. `imem_req`=0, `instr_valid`=0, `fetch_err`=1.
- Arithmetic:
  - 32-bit, modulo 2^32. 32'hFFFF_FFFC+4 wraps to 0, and negative `ImmOp` wraps the same way.
  - No overflow flag.
- `imem_ack` outside REQ is ignored.
- `PCsrc` and `ImmOp` are ignored outside the HOLD accept cycle.

## Timing
- Reset values:
  - `PC`=`RESET_PC`
  - state IDLE
  - `imem_req`=0
  - `instr`=32'h0000_0013 (NOP)
  - `instr_valid`=0
  - `fetch_err`=0
- Latency:
  - The request issues 1 cycle after reset release.
  - `instr_valid` rises 1 cycle after the `imem_ack` edge.
  - The next request issues the cycle after acceptance.
  - Best-case throughput is 1 instruction per 2 cycles (zero-wait memory, `instr_ready` tied high).
- Outputs are registered or decoded from state only. No combinational path from `imem_ack` or `instr_ready` to any output.
- Exactly one request outstanding. A new request is never issued before the previous instruction is accepted.
- Reset mid-request: the outstanding request is abandoned and `imem_req` drops asynchronously. A late `imem_ack` arriving in IDLE is ignored.
- Reset in HOLD: `instr_valid` drops asynchronously and the pending instruction is discarded.

## Structure
- Shared package `cpu_pkg`:
  - `fetch_state_t` enum {IDLE, REQ, HOLD, ERR}
  - `NOP_INSTR`=32'h0000_0013
  - `XLEN`=32
- Sub-module `pc_next`: combinational next-PC adder/mux.
  - Inputs: `PC`, `ImmOp`, `PCsrc`.
  - Outputs: `next_pc`, `misaligned`.
  - Instantiated once in `fetch_unit`.

## Test plan
- Reset with `RESET_PC`=0, zero-wait memory, `instr_ready`=1 → `imem_addr` sequence 0,4,8,…; `instr_valid` pulses every 2 cycles; `instr` matches ROM.
- `PC`=0x10, accept with `PCsrc`=1 and `ImmOp`=0xFFFF_FFF8 → next `imem_addr`=0x08. With `PCsrc`=0 it is 0x14.
- Memory ack delayed 3 cycles, then `instr_ready` held low 4 cycles → `imem_addr` is stable throughout the delay; `instr` and `PC` hold; no second request.
- `PC`=0xFFFF_FFFC, accept with `PCsrc`=0 → next fetch address is 0x0000_0000.
- Accept with `PCsrc`=1 and `ImmOp`=0x6 → `fetch_err`=1; `imem_req` and `instr_valid` stay 0 until reset; `PC` is unchanged.
- Assert `rst` while `imem_req`=1 and pulse `imem_ack` during reset and the following IDLE cycle → all outputs take reset values immediately and the first post-reset fetch is at `RESET_PC`.
